// File: rtl/lut_neuron_loader_if.sv
// Bus bundle for lut_neuron_loader: configuration stream, evaluation port and readback.
// The readback pair (rb_addr/rb_data) is only meaningful when LUT_READBACK_EN is defined.
interface lut_neuron_loader_if #(
    parameter int unsigned IN_BITS  = 6,
    parameter int unsigned OUT_BITS = 1,
    parameter int unsigned CFG_W    = 8
);
    localparam int unsigned TOTAL = (2 ** IN_BITS) * OUT_BITS;
    localparam int unsigned BEATS = TOTAL / CFG_W;
    localparam int unsigned RB_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                cfg_start;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CFG_W-1:0]    cfg_data;
    logic                cfg_done;
    logic                table_ok;
    logic                in_valid;
    logic                in_ready;
    logic [IN_BITS-1:0]  in_data;
    logic                out_valid;
    logic [OUT_BITS-1:0] out_data;
    logic [RB_W-1:0]     rb_addr;
    logic [CFG_W-1:0]    rb_data;

    modport master (
        output cfg_start, cfg_valid, cfg_data, in_valid, in_data, rb_addr,
        input  cfg_ready, cfg_done, table_ok, in_ready, out_valid, out_data, rb_data
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, in_valid, in_data, rb_addr,
        output cfg_ready, cfg_done, table_ok, in_ready, out_valid, out_data, rb_data
    );
endinterface

// File: rtl/lut_neuron_loader.sv
// Runtime-programmable LUT neuron: streams a truth table into a shadow copy,
// commits it atomically on the last beat, and evaluates inputs with 1-cycle latency.
// Optional committed-table readback is enabled by defining LUT_READBACK_EN.
module lut_neuron_loader #(
    parameter int unsigned IN_BITS  = 6,
    parameter int unsigned OUT_BITS = 1,
    parameter int unsigned CFG_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    lut_neuron_loader_if.slave     bus
);
    localparam int unsigned TOTAL = (2 ** IN_BITS) * OUT_BITS;
    localparam int unsigned BEATS = TOTAL / CFG_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {EMPTY, LOAD, ARMED} state_t;

    state_t              state_q, state_n;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_n;
    logic [TOTAL-1:0]    shadow_q, shadow_n;
    logic [TOTAL-1:0]    committed_q;
    logic                commit;
    logic                cfg_ready_q;
    logic                cfg_done_q;
    logic                table_ok_q;
    logic                out_valid_q;
    logic [OUT_BITS-1:0] out_data_q;
    logic                eval_fire;

    assign eval_fire = bus.in_valid & table_ok_q;

    // Next-state, beat counter and shadow-table update; a restart beats a coincident beat.
    always_comb begin
        state_n    = state_q;
        beat_cnt_n = beat_cnt_q;
        shadow_n   = shadow_q;
        commit     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (bus.cfg_start) begin
                    state_n    = LOAD;
                    beat_cnt_n = '0;
                end
            end
            LOAD: begin
                if (bus.cfg_start) begin
                    beat_cnt_n = '0;
                end else if (bus.cfg_valid) begin
                    shadow_n[32'(beat_cnt_q) * CFG_W +: CFG_W] = bus.cfg_data;
                    if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
                        commit     = 1'b1;
                        state_n    = ARMED;
                        beat_cnt_n = '0;
                    end else begin
                        beat_cnt_n = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            ARMED: begin
                if (bus.cfg_start) begin
                    state_n    = LOAD;
                    beat_cnt_n = '0;
                end
            end
            default: begin
                state_n    = EMPTY;
                beat_cnt_n = '0;
            end
        endcase
    end

    // State, tables and configuration-side status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            beat_cnt_q  <= '0;
            shadow_q    <= '0;
            committed_q <= '0;
            cfg_ready_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            table_ok_q  <= 1'b0;
        end else begin
            state_q     <= state_n;
            beat_cnt_q  <= beat_cnt_n;
            shadow_q    <= shadow_n;
            cfg_ready_q <= (state_n == LOAD);
            cfg_done_q  <= commit;
            if (commit) begin
                committed_q <= shadow_n;
                table_ok_q  <= 1'b1;
            end
        end
    end

    // Evaluation pipeline; reads the pre-commit table on a commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= eval_fire;
            if (eval_fire) begin
                out_data_q <= committed_q[32'(bus.in_data) * OUT_BITS +: OUT_BITS];
            end
        end
    end

`ifdef LUT_READBACK_EN
    logic [CFG_W-1:0] rb_data_q;

    // Registered readback of one committed-table word; out-of-range addresses read 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_data_q <= '0;
        end else if (32'(bus.rb_addr) < BEATS) begin
            rb_data_q <= committed_q[32'(bus.rb_addr) * CFG_W +: CFG_W];
        end else begin
            rb_data_q <= '0;
        end
    end

    assign bus.rb_data = rb_data_q;
`else
    logic rb_addr_unused;

    assign rb_addr_unused = ^bus.rb_addr;
    assign bus.rb_data    = '0;
`endif

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.cfg_done  = cfg_done_q;
    assign bus.table_ok  = table_ok_q;
    assign bus.in_ready  = table_ok_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule
